// File: rtl/uart_tx_framer.sv
// uart_tx_framer: wraps the cmd_encoder byte stream (ADDR, LEN, PAYLOAD...) into
// SYNC/ADDR/LEN/PAYLOAD/CSUM frames for the uart transmitter. A single output
// register sits between the encoder and the uart. A stall inside a frame aborts it.
module uart_tx_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'h5A,
  parameter bit         USE_SYNC  = 1'b1,
  parameter int         TIMEOUT   = 4800,
  parameter int         TO_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, ADDR, LEN, PAYLOAD, CSUM, CDONE} state_t;

  // Limit value for the idle counter; only meaningful when TIMEOUT != 0.
  localparam logic [TO_W-1:0] TO_LIM = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  logic [7:0]      sum;
  logic [7:0]      len_cnt;
  logic [TO_W-1:0] to_cnt;

  logic free, accept, in_body, to_hit;

  // Output slot can take a new byte when empty or draining this cycle.
  assign free    = !m_valid || m_ready;
  assign s_ready = free && (state == ADDR || state == LEN || state == PAYLOAD);
  assign accept  = s_valid && s_ready;
  // Only LEN and PAYLOAD wait on the encoder mid-message, so only they can time out.
  assign in_body = (state == LEN) || (state == PAYLOAD);
  // An accept on the limit cycle wins over the abort.
  assign to_hit  = (TIMEOUT != 0) && in_body && !accept && (to_cnt == TO_LIM);
  assign busy    = (state != IDLE);

  // Framing FSM, output register, checksum, length and idle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      m_data      <= 8'h00;
      m_valid     <= 1'b0;
      sum         <= 8'h00;
      len_cnt     <= 8'h00;
      to_cnt      <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;

      // Drop the byte once the uart has taken it; a new load below overrides.
      if (m_valid && m_ready) m_valid <= 1'b0;

      // Accepted input bytes go straight into the output slot.
      if (accept) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
      end

      // Idle counter only runs while waiting on the encoder mid-message.
      if (accept || !in_body || to_hit) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (USE_SYNC) begin
            // SYNC is generated locally; the pending input byte stays put.
            if (s_valid && free) begin
              m_data  <= SYNC_BYTE;
              m_valid <= 1'b1;
              state   <= ADDR;
            end
          end else if (s_valid) begin
            state <= ADDR;
          end
        end
        ADDR: begin
          if (accept) begin
            sum   <= s_data;
            state <= LEN;
          end
        end
        LEN: begin
          if (accept) begin
            sum     <= sum + s_data;
            len_cnt <= s_data;
            state   <= (s_data == 8'h00) ? CSUM : PAYLOAD;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            sum         <= 8'h00;
            state       <= IDLE;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            sum     <= sum + s_data;
            len_cnt <= len_cnt - 8'd1;
            if (len_cnt == 8'd1) state <= CSUM;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            sum         <= 8'h00;
            state       <= IDLE;
          end
        end
        CSUM: begin
          if (free) begin
            m_data  <= sum;
            m_valid <= 1'b1;
            state   <= CDONE;
          end
        end
        CDONE: begin
          // m_valid here is the checksum byte; the frame ends on its handshake.
          if (m_valid && m_ready) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: one instance with SYNC and TIMEOUT=16,
// one with USE_SYNC=0. Output bytes are collected on each handshake.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0, s_valid2 = 1'b0;
  logic       m_ready = 1'b1;
  logic       s_ready, m_valid, busy, frame_done, timeout_err;
  logic [7:0] m_data;
  logic       s_ready2, m_valid2, busy2, frame_done2, timeout_err2;
  logic [7:0] m_data2;

  int         total = 0, pass_cnt = 0;
  bit         rand_rdy = 1'b0;
  logic [7:0] obs[$], obs2[$], txq[$], exp_q[$];
  int         fd_cnt = 0, te_cnt = 0, fd2_cnt = 0;
  logic [7:0] fd_last;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  uart_tx_framer #(.SYNC_BYTE(8'h5A), .USE_SYNC(1'b1), .TIMEOUT(16), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err));

  uart_tx_framer #(.SYNC_BYTE(8'h5A), .USE_SYNC(1'b0), .TIMEOUT(4800), .TO_W(16)) dut2 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid2), .s_ready(s_ready2),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready), .busy(busy2),
    .frame_done(frame_done2), .timeout_err(timeout_err2));

  // Collect handshakes and pulses; check output holds steady while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data)
          $display("FAIL stall_hold: m_valid=%b m_data=%h, required 1 %h", m_valid, m_data, prev_data);
        else pass_cnt++;
      end
      if (m_valid && m_ready) obs.push_back(m_data);
      if (m_valid2 && m_ready) obs2.push_back(m_data2);
      if (frame_done) begin fd_cnt++; fd_last = obs[obs.size()-1]; end
      if (frame_done2) fd2_cnt++;
      if (timeout_err) te_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic send_bytes(input bit sel);
    bit acc;
    int guard;
    for (int i = 0; i < txq.size(); i++) begin
      s_data = txq[i];
      if (sel) s_valid2 = 1'b1; else s_valid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 300) begin
        @(negedge clk);
        acc = sel ? s_ready2 : s_ready;
        @(posedge clk); #1;
        guard++;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
      end
      if (!acc) begin
        total++;
        $display("FAIL send_accept: byte %0d not accepted, s_ready=0 required 1", i);
      end
    end
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int guard = 0;
    while (guard < 2000) begin
      @(negedge clk);
      if (sel ? (!busy2 && !m_valid2) : (!busy && !m_valid)) break;
      @(posedge clk); #1;
      guard++;
      if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end
    if (guard >= 2000) begin
      total++;
      $display("FAIL wait_idle: busy=%b required 0", sel ? busy2 : busy);
    end
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs.delete(); obs2.delete();
    fd_cnt = 0; fd2_cnt = 0; te_cnt = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({m_valid, m_data, busy, s_ready, frame_done, timeout_err} !== 12'h0)
      $display("FAIL reset_state: mv=%b md=%h busy=%b sr=%b fd=%b te=%b, required all 0",
               m_valid, m_data, busy, s_ready, frame_done, timeout_err);
    else pass_cnt++;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_obs();
    txq = '{8'h16, 8'h02, 8'h01, 8'h02};
    exp_q = '{8'h5A, 8'h16, 8'h02, 8'h01, 8'h02, 8'h1B};
    send_bytes(1'b0);
    wait_idle(1'b0);
    total++;
    if (obs.size() != exp_q.size()) $display("FAIL basic_len: got %0d bytes, required %0d", obs.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) $display("FAIL basic_byte%0d: got %h, required %h", i, obs[i], exp_q[i]);
      else pass_cnt++;
    end
    total++;
    if (fd_cnt != 1 || fd_last !== 8'h1B)
      $display("FAIL basic_done: frame_done count %0d after %h, required 1 after 1b", fd_cnt, fd_last);
    else pass_cnt++;
    total++;
    if (busy !== 1'b0 || te_cnt != 0) $display("FAIL basic_idle: busy=%b te=%0d, required 0 0", busy, te_cnt);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    clear_obs();
    txq = '{8'h09, 8'h00};
    exp_q = '{8'h5A, 8'h09, 8'h00, 8'h09};
    send_bytes(1'b0);
    wait_idle(1'b0);
    total++;
    if (obs != exp_q) $display("FAIL zero_len: got %p, required %p", obs, exp_q);
    else pass_cnt++;
    total++;
    if (fd_cnt != 1) $display("FAIL zero_len_done: frame_done count %0d, required 1", fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_wrap_backpressure();
    clear_obs();
    rand_rdy = 1'b1;
    txq = '{8'hFF, 8'h01, 8'h02};
    exp_q = '{8'h5A, 8'hFF, 8'h01, 8'h02, 8'h02};
    send_bytes(1'b0);
    wait_idle(1'b0);
    rand_rdy = 1'b0;
    total++;
    if (obs != exp_q) $display("FAIL wrap_bp: got %p, required %p", obs, exp_q);
    else pass_cnt++;
    total++;
    if (fd_cnt != 1) $display("FAIL wrap_bp_done: frame_done count %0d, required 1", fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_obs();
    txq = '{8'h16, 8'h03, 8'h01};
    send_bytes(1'b0);
    while (n < 40) begin
      @(negedge clk);
      if (timeout_err) break;
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != 16) $display("FAIL timeout_delay: pulse after %0d cycles, required 16", n);
    else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL timeout_idle: busy=%b, required 0", busy);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_pulse: timeout_err=%b, required 0", timeout_err);
    else pass_cnt++;
    exp_q = '{8'h5A, 8'h16, 8'h03, 8'h01};
    total++;
    if (obs != exp_q || fd_cnt != 0)
      $display("FAIL timeout_no_csum: got %p fd=%0d, required %p fd=0", obs, fd_cnt, exp_q);
    else pass_cnt++;
    clear_obs();
    txq = '{8'h16, 8'h00};
    exp_q = '{8'h5A, 8'h16, 8'h00, 8'h16};
    send_bytes(1'b0);
    wait_idle(1'b0);
    total++;
    if (obs != exp_q) $display("FAIL timeout_next: got %p, required %p", obs, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_obs();
    txq = '{8'h16, 8'h00, 8'h09, 8'h01, 8'h33};
    exp_q = '{8'h5A, 8'h16, 8'h00, 8'h16, 8'h5A, 8'h09, 8'h01, 8'h33, 8'h3D};
    send_bytes(1'b0);
    wait_idle(1'b0);
    total++;
    if (obs != exp_q) $display("FAIL b2b: got %p, required %p", obs, exp_q);
    else pass_cnt++;
    total++;
    if (fd_cnt != 2) $display("FAIL b2b_done: frame_done count %0d, required 2", fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_no_sync();
    clear_obs();
    txq = '{8'h0A, 8'h01, 8'h55};
    exp_q = '{8'h0A, 8'h01, 8'h55, 8'h60};
    send_bytes(1'b1);
    wait_idle(1'b1);
    total++;
    if (obs2 != exp_q || fd2_cnt != 1)
      $display("FAIL no_sync: got %p fd=%0d, required %p fd=1", obs2, fd2_cnt, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_obs();
    txq = '{8'h16, 8'h05, 8'h11};
    send_bytes(1'b0);
    m_ready = 1'b0;
    s_data = 8'h22;
    s_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if (m_valid !== 1'b1 || busy !== 1'b1) $display("FAIL rst_pre: mv=%b busy=%b, required 1 1", m_valid, busy);
    else pass_cnt++;
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 8'h00)
      $display("FAIL rst_mid: mv=%b busy=%b md=%h, required 0 0 00", m_valid, busy, m_data);
    else pass_cnt++;
    m_ready = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    clear_obs();
    txq = '{8'h16, 8'h01, 8'hAA};
    exp_q = '{8'h5A, 8'h16, 8'h01, 8'hAA, 8'hC1};
    send_bytes(1'b0);
    wait_idle(1'b0);
    total++;
    if (obs != exp_q || fd_cnt != 1)
      $display("FAIL rst_next: got %p fd=%0d, required %p fd=1", obs, fd_cnt, exp_q);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap_backpressure();
    test_timeout();
    test_back_to_back();
    test_no_sync();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
